// File: rtl/design_select_ctrl.sv
// Design-select control: synchronizes and debounces the pad select field, then runs a
// drain / reset-hold / enable hand-over. Optional macro DESIGN_SELECT_LOCK_EN adds sel_lock.
module design_select_ctrl #(
   parameter int NUM_DESIGNS     = 16,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int RST_HOLD_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [3:0]             design_select_in,
`ifdef DESIGN_SELECT_LOCK_EN
   input  logic                   sel_lock,
`endif
   output logic [3:0]             active_sel,
   output logic [NUM_DESIGNS-1:0] design_en,
   output logic [NUM_DESIGNS-1:0] design_n_rst,
   output logic                   gpio_oeb_force,
   output logic                   switching
);

   localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RCNT_W = (RST_HOLD_CYCLES > 2) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] RST_MAX   = RCNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [4:0]        NUM_SLOTS = 5'(NUM_DESIGNS);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      RESET,
      RUN
   } state_t;

   state_t                 state;
   logic [3:0]             sync1;
   logic [3:0]             sel_sync;
   logic [3:0]             candidate;
   logic [CNT_W-1:0]       cnt;
   logic [RCNT_W-1:0]      rst_cnt;
   logic                   stable;
   logic                   valid;
   logic                   lock_ok;
   logic                   trigger;
   logic [3:0]             target;
   logic [NUM_DESIGNS-1:0] run_onehot;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1    <= '0;
         sel_sync <= '0;
      end else begin
         sync1    <= design_select_in;
         sel_sync <= sync1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         candidate <= '0;
         cnt       <= '0;
      end else if (sel_sync != candidate) begin
         candidate <= sel_sync;
         cnt       <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

`ifdef DESIGN_SELECT_LOCK_EN
   assign lock_ok = ~sel_lock;
`else
   assign lock_ok = 1'b1;
`endif

   // Out-of-range and zero selections both fall back to the idle slot.
   assign stable     = (cnt == CNT_MAX);
   assign valid      = (candidate != 4'd0) && ({1'b0, candidate} < NUM_SLOTS);
   assign target     = valid ? candidate : 4'd0;
   assign trigger    = stable && (target != active_sel) && lock_ok;
   assign run_onehot = NUM_DESIGNS'(1) << active_sel;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state          <= IDLE;
         active_sel     <= '0;
         rst_cnt        <= '0;
         design_en      <= '0;
         design_n_rst   <= '0;
         gpio_oeb_force <= 1'b1;
         switching      <= 1'b0;
      end else begin
         case (state)
            IDLE, RUN: begin
               // The old design keeps its reset released while draining so it can park its pins.
               if (trigger) begin
                  state          <= DRAIN;
                  design_en      <= '0;
                  gpio_oeb_force <= 1'b1;
                  switching      <= 1'b1;
               end
            end
            DRAIN: begin
               state        <= RESET;
               active_sel   <= target;
               rst_cnt      <= '0;
               design_n_rst <= '0;
            end
            RESET: begin
               if (rst_cnt < RST_MAX) begin
                  rst_cnt <= rst_cnt + RCNT_W'(1);
               end else if (active_sel != 4'd0) begin
                  state          <= RUN;
                  design_en      <= run_onehot;
                  design_n_rst   <= run_onehot;
                  gpio_oeb_force <= 1'b0;
                  switching      <= 1'b0;
               end else begin
                  state     <= IDLE;
                  switching <= 1'b0;
               end
            end
            default: begin
               state          <= IDLE;
               design_en      <= '0;
               design_n_rst   <= '0;
               gpio_oeb_force <= 1'b1;
               switching      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_design_select_ctrl.sv
// Scoreboard bench for design_select_ctrl: per-cycle expected outputs are queued from the
// hand-over timeline when the pad is driven, then popped and compared each clock.
module tb_design_select_ctrl;

   localparam int NUM_DESIGNS     = 8;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int RST_HOLD_CYCLES = 3;

   localparam logic [7:0] OH2 = 8'h04;
   localparam logic [7:0] OH3 = 8'h08;
   localparam logic [7:0] OH5 = 8'h20;
   localparam logic [7:0] OH6 = 8'h40;

   logic                   clk = 1'b0;
   logic                   n_rst = 1'b1;
   logic [3:0]             design_select_in = 4'd0;
   logic [3:0]             active_sel;
   logic [NUM_DESIGNS-1:0] design_en;
   logic [NUM_DESIGNS-1:0] design_n_rst;
   logic                   gpio_oeb_force;
   logic                   switching;

   logic [31:0] exp_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   string       scenario;

   always #5 clk = ~clk;

   design_select_ctrl #(
      .NUM_DESIGNS    (NUM_DESIGNS),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_HOLD_CYCLES(RST_HOLD_CYCLES)
   ) dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .design_select_in(design_select_in),
      .active_sel      (active_sel),
      .design_en       (design_en),
      .design_n_rst    (design_n_rst),
      .gpio_oeb_force  (gpio_oeb_force),
      .switching       (switching)
   );

   // Snapshot layout: {active_sel, design_en, design_n_rst, gpio_oeb_force, switching}
   function automatic logic [31:0] pack(input logic [3:0] act, input logic [7:0] en,
                                        input logic [7:0] nrst, input logic force_oeb,
                                        input logic sw);
      return {10'b0, act, en, nrst, force_oeb, sw};
   endfunction

   function automatic logic [31:0] observed();
      return {10'b0, active_sel, design_en, design_n_rst, gpio_oeb_force, switching};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %06h expected %06h", tag, got, want);
      end
   endtask

   task automatic pushExp(input int n, input logic [31:0] v);
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic applyStimulus(input logic [3:0] pad, input int cycles);
      logic [31:0] want;
      design_select_in = pad;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s_queued[%0d]", scenario, i), {31'b0, exp_q.size() > 0}, 32'd1);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checkOutput($sformatf("%s[%0d]", scenario, i), observed(), want);
         end
         checkOutput($sformatf("%s_onehot[%0d]", scenario, i),
                     {31'b0, $countones(design_en) <= 1}, 32'd1);
      end
   endtask

   initial begin
      logic [31:0] idle_v;
      idle_v = pack(4'd0, 8'h00, 8'h00, 1'b1, 1'b0);

      scenario = "reset";
      #2 n_rst = 1'b0;
      #1 checkOutput("reset_async", observed(), idle_v);
      pushExp(2, idle_v);
      applyStimulus(4'd0, 2);
      n_rst = 1'b1;

      scenario = "idle";
      pushExp(20, idle_v);
      applyStimulus(4'd0, 20);

      // Pad 0->3: drain at k+6, reset hold k+7..k+9, design 3 enabled at k+10.
      scenario = "switch3";
      pushExp(6, idle_v);
      pushExp(1, pack(4'd0, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(3, pack(4'd3, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(4, pack(4'd3, OH3, OH3, 1'b0, 1'b0));
      applyStimulus(4'd3, 14);

      scenario = "glitch";
      pushExp(12, pack(4'd3, OH3, OH3, 1'b0, 1'b0));
      applyStimulus(4'd5, 3);
      applyStimulus(4'd3, 9);

      scenario = "out_of_range";
      pushExp(6, pack(4'd3, OH3, OH3, 1'b0, 1'b0));
      pushExp(1, pack(4'd3, 8'h00, OH3, 1'b1, 1'b1));
      pushExp(3, pack(4'd0, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(4, idle_v);
      applyStimulus(4'd12, 14);

      scenario = "back_to3";
      pushExp(6, idle_v);
      pushExp(1, pack(4'd0, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(3, pack(4'd3, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(4, pack(4'd3, OH3, OH3, 1'b0, 1'b0));
      applyStimulus(4'd3, 14);

      // The synchronized select moves to 2 while design 5 is held in reset, so 5 runs one cycle.
      scenario = "reswitch";
      pushExp(6, pack(4'd3, OH3, OH3, 1'b0, 1'b0));
      pushExp(1, pack(4'd3, 8'h00, OH3, 1'b1, 1'b1));
      pushExp(3, pack(4'd5, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(1, pack(4'd5, OH5, OH5, 1'b0, 1'b0));
      pushExp(1, pack(4'd5, 8'h00, OH5, 1'b1, 1'b1));
      pushExp(3, pack(4'd2, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(3, pack(4'd2, OH2, OH2, 1'b0, 1'b0));
      applyStimulus(4'd5, 5);
      applyStimulus(4'd2, 13);

      scenario = "to6";
      pushExp(6, pack(4'd2, OH2, OH2, 1'b0, 1'b0));
      pushExp(1, pack(4'd2, 8'h00, OH2, 1'b1, 1'b1));
      pushExp(1, pack(4'd6, 8'h00, 8'h00, 1'b1, 1'b1));
      applyStimulus(4'd6, 8);
      n_rst = 1'b0;
      #1 checkOutput("nrst_async", observed(), idle_v);
      scenario = "nrst_hold";
      pushExp(2, idle_v);
      applyStimulus(4'd6, 2);
      n_rst = 1'b1;

      scenario = "after_nrst";
      pushExp(6, idle_v);
      pushExp(1, pack(4'd0, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(3, pack(4'd6, 8'h00, 8'h00, 1'b1, 1'b1));
      pushExp(4, pack(4'd6, OH6, OH6, 1'b0, 1'b0));
      applyStimulus(4'd6, 14);

      checkOutput("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
